// File: rtl/memory_write_control_pkg.sv
// Shared types and constants for the frame-memory write path.
package memory_write_control_pkg;

  localparam int PIX_WIDTH    = 24;
  localparam int PIX_PER_WORD = 4;

  typedef enum logic [1:0] {
    S_WIDLE   = 2'd0,
    S_WWAIT   = 2'd1,
    S_WACTIVE = 2'd2
  } Wstate_t;

endpackage

// File: rtl/memory_write_control_pixel_packer.sv
// Packs consecutive pixels into one memory word, lowest slot first.
// A completed or flushed word is presented combinationally for one cycle;
// the caller registers it. Unused slots of a flushed word are zero.
module memory_write_control_pixel_packer #(
  parameter  int DATA_WIDTH   = 96,
  parameter  int PIX_PER_WORD = 4,
  localparam int PIX_WIDTH    = DATA_WIDTH / PIX_PER_WORD,
  localparam int SLOT_WIDTH   = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1
) (
  input  logic                  i_clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_store,
  input  logic                  i_flush,
  input  logic [PIX_WIDTH-1:0]  i_pixel,
  output logic                  o_word_valid,
  output logic [DATA_WIDTH-1:0] o_word
);

  localparam logic [SLOT_WIDTH-1:0] SLOT_LAST = SLOT_WIDTH'(PIX_PER_WORD - 1);

  logic [SLOT_WIDTH-1:0] slot_q, slot_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] inserted;

  // Insert the pixel at the current slot; emit the word when full or on flush.
  always_comb begin
    inserted = data_q;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      if (slot_q == SLOT_WIDTH'(i)) begin
        inserted[i*PIX_WIDTH +: PIX_WIDTH] = i_pixel;
      end
    end
    slot_d       = slot_q;
    data_d       = data_q;
    o_word_valid = 1'b0;
    o_word       = inserted;
    if (i_clear) begin
      slot_d = '0;
      data_d = '0;
    end else if (i_flush) begin
      o_word       = data_q;
      o_word_valid = (slot_q != '0);
      slot_d       = '0;
      data_d       = '0;
    end else if (i_store) begin
      if (slot_q == SLOT_LAST) begin
        o_word_valid = 1'b1;
        slot_d       = '0;
        data_d       = '0;
      end else begin
        slot_d = slot_q + SLOT_WIDTH'(1);
        data_d = inserted;
      end
    end
  end

  // Slot index and partial word storage.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      data_q <= '0;
    end else begin
      slot_q <= slot_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/memory_write_control.sv
// Write side of the frame memory: packs a DE-qualified pixel stream into
// words and writes them at a linearly incrementing address per frame.
// Optional sticky status outputs o_ovf/o_line_err: MEMORY_WRITE_STATUS_EN.
module memory_write_control #(
  parameter  int DATA_WIDTH   = memory_write_control_pkg::PIX_WIDTH *
                                memory_write_control_pkg::PIX_PER_WORD,
  parameter  int PIX_PER_WORD = memory_write_control_pkg::PIX_PER_WORD,
  parameter  int ADDR_DEPTH   = 512 * 512 / 4,
  parameter  int ADDR_WIDTH   = $clog2(ADDR_DEPTH),
  localparam int PIX_W        = DATA_WIDTH / PIX_PER_WORD
) (
  input  logic                  i_clk,
  input  logic                  rst_n,
  input  logic                  i_vsync,
  input  logic                  i_de,
  input  logic [PIX_W-1:0]      i_pixel,
  input  logic [10:0]           i_hres,
  input  logic [10:0]           i_vres,
  output logic                  o_wen,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_frame_done,
`ifdef MEMORY_WRITE_STATUS_EN
  output logic                  o_ovf,
  output logic                  o_line_err,
`endif
  output logic                  o_busy
);

  import memory_write_control_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(ADDR_DEPTH - 1);

  Wstate_t               state_q, state_d;
  logic                  vsync_q;
  logic                  rise;
  logic [10:0]           hres_q, hres_d, vres_q, vres_d;
  logic [10:0]           line_q, line_d, pix_q, pix_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, waddr_q, waddr_d;
  logic                  full_q, full_d;
  logic                  wen_q, wen_d, done_q, done_d, busy_q, busy_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  pk_clear, pk_store, pk_flush, pk_word_valid;
  logic [DATA_WIDTH-1:0] pk_word;
  logic                  zero_cfg, last_line, line_end_last;

  assign rise      = i_vsync & ~vsync_q;
  assign zero_cfg  = (hres_q == 11'd0) || (vres_q == 11'd0);
  assign last_line = ((line_q + 11'd1) == vres_q);

  memory_write_control_pixel_packer #(
    .DATA_WIDTH   (DATA_WIDTH),
    .PIX_PER_WORD (PIX_PER_WORD)
  ) u_packer (
    .i_clk        (i_clk),
    .rst_n        (rst_n),
    .i_clear      (pk_clear),
    .i_store      (pk_store),
    .i_flush      (pk_flush),
    .i_pixel      (i_pixel),
    .o_word_valid (pk_word_valid),
    .o_word       (pk_word)
  );

  // Frame/line sequencing: a vsync rise restarts the frame from any state.
  always_comb begin
    state_d       = state_q;
    hres_d        = hres_q;
    vres_d        = vres_q;
    line_d        = line_q;
    pix_d         = pix_q;
    pk_clear      = 1'b0;
    pk_store      = 1'b0;
    pk_flush      = 1'b0;
    line_end_last = 1'b0;
    if (rise) begin
      pk_clear = 1'b1;
      hres_d   = i_hres;
      vres_d   = i_vres;
      line_d   = 11'd0;
      pix_d    = 11'd0;
      state_d  = S_WWAIT;
    end else begin
      case (state_q)
        S_WWAIT: begin
          if (i_de) begin
            state_d = S_WACTIVE;
            if (!zero_cfg) begin
              pk_store = 1'b1;
              pix_d    = 11'd1;
            end
          end
        end
        S_WACTIVE: begin
          if (i_de) begin
            if (!zero_cfg && (pix_q < hres_q)) begin
              pk_store = 1'b1;
              pix_d    = pix_q + 11'd1;
            end
          end else begin
            pk_flush = 1'b1;
            pix_d    = 11'd0;
            line_d   = line_q + 11'd1;
            if (zero_cfg) begin
              state_d = S_WIDLE;
            end else if (last_line) begin
              state_d       = S_WIDLE;
              line_end_last = 1'b1;
            end else begin
              state_d = S_WWAIT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Address generation, overflow suppression and frame-done timing.
  // When the last line's final stored pixel completes a word, frame done
  // rides with that write; otherwise it rides with the line-end flush.
  always_comb begin
    addr_d  = addr_q;
    full_d  = full_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    if (rise) begin
      addr_d = '0;
      full_d = 1'b0;
    end else begin
      if (pk_word_valid && !full_q) begin
        wen_d   = 1'b1;
        waddr_d = addr_q;
        wdata_d = pk_word;
        if (addr_q == ADDR_LAST) begin
          full_d = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      done_d = (line_end_last && ((pix_q != hres_q) || pk_word_valid)) ||
               (pk_store && pk_word_valid && last_line &&
                ((pix_q + 11'd1) == hres_q));
    end
    busy_d = (state_d != S_WIDLE);
  end

  // All state and registered outputs.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WIDLE;
      vsync_q <= 1'b0;
      hres_q  <= '0;
      vres_q  <= '0;
      line_q  <= '0;
      pix_q   <= '0;
      addr_q  <= '0;
      full_q  <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= i_vsync;
      hres_q  <= hres_d;
      vres_q  <= vres_d;
      line_q  <= line_d;
      pix_q   <= pix_d;
      addr_q  <= addr_d;
      full_q  <= full_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign o_wen        = wen_q;
  assign o_waddr      = waddr_q;
  assign o_wdata      = wdata_q;
  assign o_frame_done = done_q;
  assign o_busy       = busy_q;

`ifdef MEMORY_WRITE_STATUS_EN
  logic ovf_q, ovf_d, line_err_q, line_err_d, long_q, long_d;

  // Sticky status: suppressed writes and lines whose length differs from hres.
  always_comb begin
    ovf_d      = ovf_q;
    line_err_d = line_err_q;
    long_d     = long_q;
    if (rise) begin
      ovf_d      = 1'b0;
      line_err_d = 1'b0;
      long_d     = 1'b0;
    end else begin
      if (pk_word_valid && full_q) begin
        ovf_d = 1'b1;
      end
      if ((state_q == S_WACTIVE) && !zero_cfg) begin
        if (i_de) begin
          if (pix_q == hres_q) begin
            long_d = 1'b1;
          end
        end else begin
          if ((pix_q != hres_q) || long_q) begin
            line_err_d = 1'b1;
          end
          long_d = 1'b0;
        end
      end
    end
  end

  // Status flops.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q      <= 1'b0;
      line_err_q <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      ovf_q      <= ovf_d;
      line_err_q <= line_err_d;
      long_q     <= long_d;
    end
  end

  assign o_ovf      = ovf_q;
  assign o_line_err = line_err_q;
`else
  // Status outputs and their tracking logic are not built.
`endif

endmodule

// File: tb/tb_memory_write_control.sv
// Directed, table-driven bench for memory_write_control (ADDR_DEPTH = 4 so
// the overflow path is reachable). Status outputs are checked only when
// MEMORY_WRITE_STATUS_EN is defined.
module tb_memory_write_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsync, de;
  logic [23:0] pixel;
  logic [10:0] hres, vres;
  logic        wen;
  logic [1:0]  waddr;
  logic [95:0] wdata;
  logic        frame_done, busy;
`ifdef MEMORY_WRITE_STATUS_EN
  logic        ovf, line_err;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        vs;
    logic        de;
    logic [23:0] pix;
    logic [10:0] hres;
    logic [10:0] vres;
    logic        ewen;
    int          eaddr;
    logic [95:0] edata;
    logic        edone;
    logic        ebusy;
    logic        eovf;
    logic        elerr;
  } vec_t;

  vec_t        vecs[$];
  logic [10:0] cur_hres, cur_vres;
  logic        exp_ovf, exp_lerr;

  memory_write_control #(
    .DATA_WIDTH   (96),
    .PIX_PER_WORD (4),
    .ADDR_DEPTH   (4)
  ) dut (
    .i_clk        (clk),
    .rst_n        (rst_n),
    .i_vsync      (vsync),
    .i_de         (de),
    .i_pixel      (pixel),
    .i_hres       (hres),
    .i_vres       (vres),
    .o_wen        (wen),
    .o_waddr      (waddr),
    .o_wdata      (wdata),
    .o_frame_done (frame_done),
`ifdef MEMORY_WRITE_STATUS_EN
    .o_ovf        (ovf),
    .o_line_err   (line_err),
`endif
    .o_busy       (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Expected packed word: p0 in the lowest slot.
  function automatic logic [95:0] w4(input int p0, input int p1, input int p2, input int p3);
    return {p3[23:0], p2[23:0], p1[23:0], p0[23:0]};
  endfunction

  task automatic addVec(input logic vs, input logic d, input int pix,
                        input logic ewen, input int eaddr, input logic [95:0] edata,
                        input logic edone, input logic ebusy);
    vec_t v;
    v.vs    = vs;
    v.de    = d;
    v.pix   = pix[23:0];
    v.hres  = cur_hres;
    v.vres  = cur_vres;
    v.ewen  = ewen;
    v.eaddr = eaddr;
    v.edata = edata;
    v.edone = edone;
    v.ebusy = ebusy;
    v.eovf  = exp_ovf;
    v.elerr = exp_lerr;
    vecs.push_back(v);
  endtask

  task automatic checkVal(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and step to just after the clock edge.
  task automatic applyStimulus(input logic vs, input logic d, input logic [23:0] pix,
                               input logic [10:0] hr, input logic [10:0] vr);
    vsync = vs;
    de    = d;
    pixel = pix;
    hres  = hr;
    vres  = vr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    checkVal({tag, " wen"}, 96'(wen), 96'(v.ewen));
    if (v.ewen) begin
      checkVal({tag, " waddr"}, 96'(waddr), 96'(v.eaddr));
      checkVal({tag, " wdata"}, wdata, v.edata);
    end
    checkVal({tag, " frame_done"}, 96'(frame_done), 96'(v.edone));
    checkVal({tag, " busy"}, 96'(busy), 96'(v.ebusy));
`ifdef MEMORY_WRITE_STATUS_EN
    checkVal({tag, " ovf"}, 96'(ovf), 96'(v.eovf));
    checkVal({tag, " line_err"}, 96'(line_err), 96'(v.elerr));
`endif
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, " wen"}, 96'(wen), 96'd0);
    checkVal({tag, " waddr"}, 96'(waddr), 96'd0);
    checkVal({tag, " wdata"}, wdata, 96'd0);
    checkVal({tag, " frame_done"}, 96'(frame_done), 96'd0);
    checkVal({tag, " busy"}, 96'(busy), 96'd0);
`ifdef MEMORY_WRITE_STATUS_EN
    checkVal({tag, " ovf"}, 96'(ovf), 96'd0);
    checkVal({tag, " line_err"}, 96'(line_err), 96'd0);
`endif
  endtask

  initial begin
    // Full words: 2 lines of 8, four writes, done with the addr3 write.
    cur_hres = 11'd8; cur_vres = 11'd2; exp_ovf = 1'b0; exp_lerr = 1'b0;
    addVec(0, 0, 0, 0, 0, 96'd0, 0, 0);
    addVec(1, 0, 0, 0, 0, 96'd0, 0, 1);
    for (int p = 1; p <= 16; p++) begin
      if (p == 9) addVec(0, 0, 0, 0, 0, 96'd0, 0, 1);
      addVec(0, 1, p, (p % 4 == 0), p / 4 - 1, w4(p - 3, p - 2, p - 1, p), (p == 16), 1);
    end
    addVec(0, 0, 0, 0, 0, 96'd0, 0, 0);

    // Partial flush; resolution inputs changed after the rise are ignored.
    cur_hres = 11'd6; cur_vres = 11'd1;
    addVec(1, 0, 0, 0, 0, 96'd0, 0, 1);
    cur_hres = 11'd2; cur_vres = 11'd3;
    for (int p = 1; p <= 6; p++) addVec(0, 1, p, (p == 4), 0, w4(1, 2, 3, 4), 0, 1);
    addVec(0, 0, 0, 1, 1, {48'd0, 24'd6, 24'd5}, 1, 0);

    // Long line, then a mid-frame restart with DE high on the rise cycle.
    cur_hres = 11'd8; cur_vres = 11'd2;
    addVec(1, 0, 0, 0, 0, 96'd0, 0, 1);
    for (int p = 1; p <= 9; p++)
      addVec(0, 1, p, (p % 4 == 0) && (p <= 8), p / 4 - 1, w4(p - 3, p - 2, p - 1, p), 0, 1);
    exp_lerr = 1'b1;
    addVec(0, 0, 0, 0, 0, 96'd0, 0, 1);
    for (int p = 21; p <= 23; p++) addVec(0, 1, p, 0, 0, 96'd0, 0, 1);
    exp_lerr = 1'b0;
    addVec(1, 1, 24, 0, 0, 96'd0, 0, 1);
    for (int p = 31; p <= 34; p++) addVec(0, 1, p, (p == 34), 0, w4(31, 32, 33, 34), 0, 1);
    addVec(0, 0, 0, 0, 0, 96'd0, 0, 1);

    // Overflow: 8 words into a 4-word memory, the last 4 suppressed.
    cur_hres = 11'd8; cur_vres = 11'd4;
    addVec(1, 0, 0, 0, 0, 96'd0, 0, 1);
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 8; p++) begin
        int val;
        int idx;
        val = l * 8 + p + 1;
        idx = l * 2 + p / 4;
        if ((p % 4 == 3) && (idx >= 4)) exp_ovf = 1'b1;
        addVec(0, 1, val, (p % 4 == 3) && (idx < 4), idx, w4(val - 3, val - 2, val - 1, val),
               (l == 3) && (p == 7), 1);
      end
      addVec(0, 0, 0, 0, 0, 96'd0, 0, (l < 3));
    end

    // Zero horizontal resolution: DE ignored, idle at first line end.
    cur_hres = 11'd0; cur_vres = 11'd2; exp_ovf = 1'b0;
    addVec(1, 0, 0, 0, 0, 96'd0, 0, 1);
    for (int p = 1; p <= 4; p++) addVec(0, 1, p, 0, 0, 96'd0, 0, 1);
    addVec(0, 0, 0, 0, 0, 96'd0, 0, 0);

    rst_n = 1'b0;
    vsync = 1'b0;
    de    = 1'b0;
    pixel = '0;
    hres  = '0;
    vres  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].vs, vecs[i].de, vecs[i].pix, vecs[i].hres, vecs[i].vres);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset mid-line clears outputs before the next edge.
    applyStimulus(1, 0, 24'd0, 11'd8, 11'd1);
    applyStimulus(0, 1, 24'd1, 11'd8, 11'd1);
    applyStimulus(0, 1, 24'd2, 11'd8, 11'd1);
    checkVal("midline busy", 96'(busy), 96'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async reset");
    @(negedge clk);
    rst_n = 1'b1;

    // New frame after reset starts at slot 0 and address 0.
    applyStimulus(0, 0, 24'd0, 11'd8, 11'd1);
    checkVal("post reset idle busy", 96'(busy), 96'd0);
    applyStimulus(1, 0, 24'd0, 11'd8, 11'd1);
    for (int p = 41; p <= 43; p++) applyStimulus(0, 1, p[23:0], 11'd8, 11'd1);
    checkVal("post reset no early write", 96'(wen), 96'd0);
    applyStimulus(0, 1, 24'd44, 11'd8, 11'd1);
    checkVal("post reset wen", 96'(wen), 96'd1);
    checkVal("post reset waddr", 96'(waddr), 96'd0);
    checkVal("post reset wdata", wdata, w4(41, 42, 43, 44));
    applyStimulus(0, 0, 24'd0, 11'd8, 11'd1);
    checkVal("short last line wen", 96'(wen), 96'd0);
    checkVal("short last line frame_done", 96'(frame_done), 96'd1);
    checkVal("short last line busy", 96'(busy), 96'd0);
`ifdef MEMORY_WRITE_STATUS_EN
    checkVal("short last line line_err", 96'(line_err), 96'd1);
`endif
    applyStimulus(0, 0, 24'd0, 11'd8, 11'd1);
    checkVal("frame_done single pulse", 96'(frame_done), 96'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
